// File: rtl/mdu_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
package mdu_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } mdu_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic is_long_op(input mdu_op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_known_op(input mdu_op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider on operand magnitudes; sign fix folded into the last step.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int ITERS = DIV_ITERS
) (
  input  logic        clk_i,
  input  logic        abort_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(ITERS);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rem_q, quo_q, dvs_q;
  logic          qneg_q, rneg_q;

  logic [32:0]   rem_sh;
  logic [31:0]   rem_sub, rem_n, quo_n;
  logic          ge;

  // Remainder below the divisor always fits 32 bits, so the low half of the subtract is exact.
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    ge      = rem_sh >= {1'b0, dvs_q};
    rem_sub = rem_sh[31:0] - dvs_q;
    rem_n   = ge ? rem_sub : rem_sh[31:0];
    quo_n   = {quo_q[30:0], ge};
    done_o  = busy_q && (cnt_q == CW'(ITERS - 1));
    quo_o   = qneg_q ? (~quo_n + 32'd1) : quo_n;
    rem_o   = rneg_q ? (~rem_n + 32'd1) : rem_n;
  end

  always_ff @(posedge clk_i) begin
    if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= signed_i ? abs32(dividend_i) : dividend_i;
      dvs_q  <= signed_i ? abs32(divisor_i) : divisor_i;
      qneg_q <= signed_i & (dividend_i[31] ^ divisor_i[31]);
      rneg_q <= signed_i & dividend_i[31];
    end else if (busy_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// HI/LO write sequencer: accepts MDU ops, runs multiply/divide, emits registered write pulses.
module mdu_hilo_ctrl
  import mdu_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] new_hi_o,
  output logic        w_hi_o,
  output logic [31:0] new_lo_o,
  output logic        w_lo_o
);

  mdu_state_t  state_q, state_d;
  mdu_op_t     op;
  logic        ready, accept, div_start, div_done;
  logic [31:0] a_q, b_q, div_quo, div_rem;
  logic        sgn_q, divz_q;
  logic [63:0] prod;

  assign op        = mdu_op_t'(op_i);
  assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = valid_i && is_known_op(op) && ready && !flush_i;
  assign div_start = accept && (op inside {OP_DIV, OP_DIVU}) && (src_b_i != '0);

  always_comb begin
    prod = sgn_q ? 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}))
                 : ({32'd0, a_q} * {32'd0, b_q});
  end

  always_comb begin
    state_d = state_q;
    stall_o = !flush_i && ((valid_i && is_long_op(op) && ready) ||
                           (state_q == S_MUL) || (state_q == S_DIV));
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          case (op)
            OP_MTHI, OP_MTLO: state_d = S_DONE;
            OP_DIV, OP_DIVU:  state_d = (src_b_i == '0) ? S_MUL : S_DIV;
            default:          state_d = S_MUL;
          endcase
        end
      end
      S_MUL:   state_d = S_DONE;
      S_DIV:   if (div_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      w_hi_o   <= 1'b0;
      w_lo_o   <= 1'b0;
      new_hi_o <= '0;
      new_lo_o <= '0;
      sgn_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_hi_o  <= 1'b0;
      w_lo_o  <= 1'b0;
      if (accept) begin
        a_q    <= src_a_i;
        b_q    <= src_b_i;
        sgn_q  <= (op == OP_MULT) || (op == OP_DIV);
        divz_q <= (op inside {OP_DIV, OP_DIVU}) && (src_b_i == '0);
        if (op == OP_MTHI) begin
          w_hi_o   <= 1'b1;
          new_hi_o <= src_a_i;
        end
        if (op == OP_MTLO) begin
          w_lo_o   <= 1'b1;
          new_lo_o <= src_a_i;
        end
      end
      // A flushed long op must never reach the HI/LO register.
      if (!flush_i && state_q == S_MUL) begin
        w_hi_o   <= 1'b1;
        w_lo_o   <= 1'b1;
        new_hi_o <= divz_q ? a_q : prod[63:32];
        new_lo_o <= divz_q ? 32'hFFFF_FFFF : prod[31:0];
      end
      if (!flush_i && state_q == S_DIV && div_done) begin
        w_hi_o   <= 1'b1;
        w_lo_o   <= 1'b1;
        new_hi_o <= div_rem;
        new_lo_o <= div_quo;
      end
    end
  end

  mdu_div_core #(.ITERS(DIV_ITERS)) u_div (
    .clk_i      (clk_i),
    .abort_i    (flush_i | rst_i),
    .start_i    (div_start),
    .signed_i   (op == OP_DIV),
    .dividend_i (src_a_i),
    .divisor_i  (src_b_i),
    .done_o     (div_done),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Randomized bench for mdu_hilo_ctrl against a latency/arithmetic scoreboard model.
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall_o, w_hi_o, w_lo_o;
  logic [31:0] new_hi_o, new_lo_o;

  int checks = 0, failures = 0;

  mdu_hilo_ctrl dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op),
    .src_a_i(a), .src_b_i(b), .flush_i(flush), .stall_o(stall_o),
    .new_hi_o(new_hi_o), .w_hi_o(w_hi_o), .new_lo_o(new_lo_o), .w_lo_o(w_lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Result and write latency of one op, straight from the arithmetic rules.
  task automatic ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l,
                        output bit wh, output bit wl, output int lat);
    longint sx, sy, p;
    logic [63:0] up;
    int ix, iy;
    h = '0; l = '0; wh = 1; wl = 1; lat = 2;
    case (o)
      OP_MULT: begin
        sx = longint'($signed(x)); sy = longint'($signed(y)); p = sx * sy;
        up = p; h = up[63:32]; l = up[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (y == 0) begin
          h = x; l = 32'hFFFF_FFFF;
        end else begin
          lat = 33;
          if (o == OP_DIVU) begin
            l = x / y; h = x % y;
          end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000; h = 0;
          end else begin
            ix = $signed(x); iy = $signed(y);
            l = ix / iy; h = ix % iy;
          end
        end
      end
      OP_MTHI: begin lat = 1; wl = 0; h = x; end
      OP_MTLO: begin lat = 1; wh = 0; l = x; end
      default: begin wh = 0; wl = 0; lat = 0; end
    endcase
  endtask

  // Scoreboard: at most one outstanding op, written at cycle `due`.
  int          cyc = 0, due = 0;
  bit          pend = 0, ewh = 0, ewl = 0, chk_en = 0;
  logic [31:0] eh = 0, el = 0, last_hi = 0, last_lo = 0;

  always @(posedge clk) begin : model
    logic [31:0] h, l;
    bit wh, wl, can;
    int lat;
    if (rst) begin
      pend = 0; last_hi = 0; last_lo = 0;
    end else begin
      can = !pend || cyc >= due;
      if (pend && cyc >= due) begin
        if (ewh) last_hi = eh;
        if (ewl) last_lo = el;
        pend = 0;
      end
      if (flush) pend = 0;
      else if (valid && can) begin
        ref_op(op, a, b, h, l, wh, wl, lat);
        if (lat > 0) begin
          pend = 1; due = cyc + lat; eh = h; el = l; ewh = wh; ewl = wl;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    bit can, busyl, islong, xh, xl, xs;
    if (chk_en) begin
      can    = !pend || cyc >= due;
      busyl  = pend && cyc < due;
      islong = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
      xs     = !flush && ((valid && islong && can) || busyl);
      xh     = pend && cyc == due && ewh;
      xl     = pend && cyc == due && ewl;
      chk("stall", stall_o, xs);
      chk("w_hi", w_hi_o, xh);
      chk("w_lo", w_lo_o, xl);
      chk("new_hi", new_hi_o, xh ? eh : last_hi);
      chk("new_lo", new_lo_o, xl ? el : last_lo);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_count(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int n, input int flush_at, output int nst, output int nw);
    valid = 1; op = o; a = x; b = y; nst = 0; nw = 0;
    for (int i = 0; i < n; i++) begin
      flush = (i == flush_at);
      @(negedge clk);
      if (stall_o) nst++;
      if (w_hi_o || w_lo_o) nw++;
      tick();
      valid = 0;
    end
    flush = 0;
  endtask

  initial begin
    logic [31:0] h, l;
    bit wh, wl;
    int lat, nst, nw;
    rst = 1; valid = 0; flush = 0; op = '0; a = '0; b = '0;

    ref_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, h, l, wh, wl, lat);
    chk("pin_mult", {h, l}, 64'hFFFF_FFFF_FFFF_FFF1);
    ref_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, wh, wl, lat);
    chk("pin_multu", {h, l}, 64'hFFFF_FFFE_0000_0001);
    ref_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, h, l, wh, wl, lat);
    chk("pin_div", {h, l}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_div_lat", lat, 33);
    ref_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l, wh, wl, lat);
    chk("pin_div_ovf", {h, l}, 64'h0000_0000_8000_0000);
    ref_op(OP_DIVU, 32'd100, 32'd0, h, l, wh, wl, lat);
    chk("pin_divz", {h, l}, 64'h0000_0064_FFFF_FFFF);

    repeat (3) tick();
    rst = 0; chk_en = 1;
    @(negedge clk);
    chk("rst_stall", stall_o, 0);
    chk("rst_w", {w_hi_o, w_lo_o}, 0);
    chk("rst_new", {new_hi_o, new_lo_o}, 0);
    tick();

    run_count(OP_MULT, 32'hFFFF_FFFD, 32'd5, 5, -1, nst, nw);
    chk("mult_stall_cycles", nst, 2); chk("mult_pulses", nw, 1);
    run_count(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, -1, nst, nw);
    chk("multu_pulses", nw, 1);
    run_count(OP_DIV, 32'hFFFF_FFF9, 32'd2, 40, -1, nst, nw);
    chk("div_stall_cycles", nst, 33); chk("div_pulses", nw, 1);
    run_count(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 40, -1, nst, nw);
    chk("div_ovf_stall_cycles", nst, 33);
    run_count(OP_DIVU, 32'd100, 32'd0, 5, -1, nst, nw);
    chk("divz_stall_cycles", nst, 2); chk("divz_pulses", nw, 1);
    run_count(OP_DIVU, 32'h8000_0000, 32'd3, 45, 10, nst, nw);
    chk("flush_pulses", nw, 0); chk("flush_stall_cycles", nst, 10);

    valid = 1; op = OP_MTHI; a = 32'h1234; nst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall_o) nst++;
      if (i == 1) chk("mt_w_t1", {w_hi_o, w_lo_o, new_hi_o}, {2'b10, 32'h1234});
      if (i == 2) chk("mt_w_t2", {w_hi_o, w_lo_o, new_lo_o}, {2'b01, 32'h5678});
      tick();
      op = OP_MTLO; a = 32'h5678; valid = (i == 0);
    end
    chk("mt_no_stall", nst, 0);

    valid = 1; op = OP_DIV; a = 32'd1000; b = 32'd7;
    for (int i = 0; i < 10; i++) begin
      rst = (i == 5);
      @(negedge clk);
      if (i == 6) chk("rst_mid_div", {stall_o, w_hi_o, w_lo_o, new_hi_o, new_lo_o}, 0);
      tick();
      valid = 0;
    end
    rst = 0;

    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom_range(0, 6));
      a     = $urandom;
      b     = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      flush = ($urandom_range(0, 29) == 0) && !(pend && cyc == due);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    valid = 0; flush = 0; rst = 0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
